alu_byte_seq: RTL and testbench

- Multi-cycle controller that performs NBYTES-wide add, subtract, reverse-subtract and compare on the shared 8-bit ALU slice, one byte per clock, LSB first.
- The slice is the conditional-inverter pair (A and B) feeding an 8-bit adder.
- This block drives the slice operands, per-operand invert controls and carry-in, chains carry between bytes, and assembles result and flags.
- Sits between the instruction decode/execute stage and the shared byte ALU.

---
 rtl/alu_byte_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_byte_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_byte_seq.sv
// Byte-serial add/sub/reverse-sub/compare sequencer driving a shared 8-bit ALU slice, LSB first.
// Optional ADC/SBC chaining (chain_in port) is built when ALU_SEQ_ADC_EN is defined.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; slice controls parked, alu_a/alu_b hold
// RUN   | one byte per cycle through the slice, index 0..NBYTES-1
// DONE  | one-cycle done pulse, result and flags valid
module alu_byte_seq #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES,
  localparam int IW = $clog2(NBYTES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
`ifdef ALU_SEQ_ADC_EN
  input  logic         chain_in,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic         neg,
  output logic         ovf,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic         inv_a,
  output logic         inv_b,
  output logic         alu_cin,
  input  logic [7:0]   alu_sum,
  input  logic         alu_cout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_RSUB = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_q, carry_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic          cy_q, cy_d, zacc_q, zacc_d;
  logic          cin_first, ea7, eb7;
`ifdef ALU_SEQ_ADC_EN
  logic          chain_q, chain_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    cy_d     = cy_q;
    zacc_d   = zacc_q;
`ifdef ALU_SEQ_ADC_EN
    chain_d  = chain_q;
`endif
    // Operand bytes follow the index; after the last byte the index parks, so they hold.
    alu_a     = a_q[{idx_q, 3'b000} +: 8];
    alu_b     = b_q[{idx_q, 3'b000} +: 8];
    inv_a     = 1'b0;
    inv_b     = 1'b0;
    alu_cin   = 1'b0;
    cin_first = 1'b0;
    ea7       = 1'b0;
    eb7       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op;
          idx_d   = '0;
`ifdef ALU_SEQ_ADC_EN
          chain_d = chain_in;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        inv_a     = (op_q == OP_RSUB);
        inv_b     = (op_q == OP_SUB) || (op_q == OP_CMP);
        cin_first = (op_q != OP_ADD);
`ifdef ALU_SEQ_ADC_EN
        // carry_q still holds the previous op's carry until this op's last edge.
        if (chain_q) cin_first = carry_q;
`endif
        alu_cin = (idx_q == '0) ? cin_first : cy_q;
        ea7     = alu_a[7] ^ inv_a;
        eb7     = alu_b[7] ^ inv_b;
        cy_d    = alu_cout;
        zacc_d  = ((idx_q == '0) ? 1'b1 : zacc_q) & (alu_sum == 8'h00);
        if (op_q != OP_CMP) result_d[{idx_q, 3'b000} +: 8] = alu_sum;
        if (idx_q == IDX_LAST) begin
          carry_d = alu_cout;
          neg_d   = alu_sum[7];
          ovf_d   = (ea7 == eb7) && (alu_sum[7] != ea7);
          zero_d  = zacc_d;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      cy_q     <= 1'b0;
      zacc_q   <= 1'b0;
`ifdef ALU_SEQ_ADC_EN
      chain_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      cy_q     <= cy_d;
      zacc_q   <= zacc_d;
`ifdef ALU_SEQ_ADC_EN
      chain_q  <= chain_d;
`endif
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_byte_seq.sv
// Directed bench for alu_byte_seq with NBYTES=4; models the shared byte slice as inverters + adder.
module tb_alu_byte_seq;
  localparam int NB = 4;
  localparam int W = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n, start, chain_in;
  logic [1:0]   op;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, carry, zero, neg, ovf;
  logic [W-1:0] result;
  logic [7:0]   alu_a, alu_b, alu_sum;
  logic         inv_a, inv_b, alu_cin, alu_cout;
  logic [8:0]   slice;

  int checks = 0;
  int failures = 0;
  int last_lat = 0;

  always #5 clk = ~clk;

  assign slice    = {1'b0, alu_a ^ {8{inv_a}}} + {1'b0, alu_b ^ {8{inv_b}}} + {8'd0, alu_cin};
  assign alu_sum  = slice[7:0];
  assign alu_cout = slice[8];

  alu_byte_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
`ifdef ALU_SEQ_ADC_EN
    .chain_in(chain_in),
`endif
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
    .neg(neg), .ovf(ovf), .alu_a(alu_a), .alu_b(alu_b), .inv_a(inv_a),
    .inv_b(inv_b), .alu_cin(alu_cin), .alu_sum(alu_sum), .alu_cout(alu_cout)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one op from IDLE and wait (bounded) for done; operand inputs are scrambled after accept.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a_in = 32'hDEAD_BEEF; b_in = 32'h5A5A_A5A5;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1);
    last_lat = lat;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] r, input logic c,
                            input logic z, input logic n, input logic v);
    check({tag, ".result"}, result, r);
    check({tag, ".carry"}, carry, c);
    check({tag, ".zero"}, zero, z);
    check({tag, ".neg"}, neg, n);
    check({tag, ".ovf"}, ovf, v);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0; chain_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.alu_a", alu_a, 0);
    check("rst.ctrl", {inv_a, inv_b, alu_cin}, 0);
    expect_res("rst", 32'h0, 0, 0, 0, 0);
    rst_n = 1'b1;

    run_op(2'b00, 32'h0000_00FF, 32'h0000_0001);
    check("add1.latency_edges", last_lat + 1, 5);
    expect_res("add1", 32'h0000_0100, 0, 0, 0, 0);
    check("add1.busy_in_done", busy, 1);
    @(negedge clk);
    check("add1.done_width", done, 0);
    check("add1.busy_after", busy, 0);
    check("add1.idle_ctrl", {inv_a, inv_b, alu_cin}, 0);

    run_op(2'b01, 32'h0000_0005, 32'h0000_0007);
    expect_res("sub", 32'hFFFF_FFFE, 0, 0, 1, 0);
    run_op(2'b10, 32'h0000_0005, 32'h0000_0007);
    expect_res("rsub", 32'h0000_0002, 1, 0, 0, 0);
    run_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001);
    expect_res("add_ovf", 32'h8000_0000, 0, 0, 1, 1);
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
    expect_res("add_wrap", 32'h0000_0000, 1, 1, 0, 0);
    run_op(2'b01, 32'h8000_0000, 32'h0000_0001);
    expect_res("sub_ovf", 32'h7FFF_FFFF, 1, 0, 0, 1);
    run_op(2'b00, 32'h1111_1111, 32'h2222_2222);
    expect_res("add_r", 32'h3333_3333, 0, 0, 0, 0);
    run_op(2'b11, 32'h1234_5678, 32'h1234_5678);
    expect_res("cmp", 32'h3333_3333, 1, 1, 0, 0);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; a_in = 32'h0000_0001; b_in = 32'h0000_0002;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("ign.busy", busy, 1);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a_in = 32'h0000_0100; b_in = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("ign.done_count", ndone, 1);
    expect_res("ign", 32'h0000_0003, 0, 0, 0, 0);

    // reset on the second RUN edge aborts the op
    run_op(2'b00, 32'h8000_0001, 32'h8000_0002);
    expect_res("pre_rst", 32'h0000_0003, 1, 0, 0, 1);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a_in = 32'h0101_0101; b_in = 32'h0101_0101;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.alu_ab", {alu_a, alu_b}, 0);
    check("abort.ctrl", {inv_a, inv_b, alu_cin}, 0);
    expect_res("abort", 32'h0, 0, 0, 0, 0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort.no_done", ndone, 0);

`ifdef ALU_SEQ_ADC_EN
    chain_in = 1'b1;
    run_op(2'b00, 32'h0000_0000, 32'h0000_0000);
    expect_res("adc_after_rst", 32'h0000_0000, 0, 1, 0, 0);
    chain_in = 1'b0;
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
    expect_res("adc_setup", 32'h0, 1, 1, 0, 0);
    chain_in = 1'b1;
    run_op(2'b00, 32'h0000_0000, 32'h0000_0000);
    expect_res("adc_chain", 32'h0000_0001, 0, 0, 0, 0);
    chain_in = 1'b0;
`else
    run_op(2'b00, 32'h0000_0000, 32'h0000_0000);
    expect_res("add_zero", 32'h0000_0000, 0, 1, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
